log_fir_accum: RTL

Log-domain inner-product engine for the log-domain FLAF datapath. It consumes the Q5.12 log-encoded weights produced by the weight-update taps, together with log-encoded expansion inputs, one tap per beat. Each pair is multiplied by adding logs, converted back to linear Q(WIDTH-QP).QP with a Mitchell antilog, and accumulated over TAPS beats. It emits one linear filter output per sample, closing the loop from the log domain back to linear.

---
 rtl/log_fir_accum_if.sv | 30 +++
 rtl/log_fir_accum.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/log_fir_accum_if.sv
// Beat-in / sample-out handshake bundle for log_fir_accum.
// master drives beats and out_ready; slave is the engine.
interface log_fir_accum_if #(
  parameter int WIDTH     = 16,
  parameter int LOG_WIDTH = 17
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LOG_WIDTH-1:0] log_a;
  logic                 log_a_sign;
  logic                 log_a_valid;
  logic [LOG_WIDTH-1:0] log_b;
  logic                 log_b_sign;
  logic                 log_b_valid;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;

  modport master (
    output in_valid, log_a, log_a_sign, log_a_valid,
    output log_b, log_b_sign, log_b_valid, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, log_a, log_a_sign, log_a_valid,
    input  log_b, log_b_sign, log_b_valid, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/log_fir_accum.sv
// Log-domain inner product: add logs, Mitchell antilog to linear Q.QP, accumulate TAPS beats.
// Define LOG_FIR_SAT_EN to saturate antilog overflow and the output instead of wrapping.
module log_fir_accum #(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LOG_WIDTH = 17,
  parameter int TAPS      = 8
) (
  input  logic           clk,
  input  logic           reset,
  log_fir_accum_if.slave bus
);
  localparam int CNT_W = $clog2(TAPS);
  localparam int ACC_W = WIDTH + $clog2(TAPS);
  localparam int SUM_W = LOG_WIDTH + 1;
  localparam int EXP_W = SUM_W - QP;
`ifdef LOG_FIR_SAT_EN
  // Wide enough for the mantissa at the largest positive exponent, so overflow is visible.
  localparam int WIDE_W = QP + 1 + (1 << (EXP_W - 1));
  localparam logic [WIDE_W-1:0] MAG_MAX = {{(WIDE_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`else
  localparam int WIDE_W = WIDTH;
`endif

  logic                    en_s;
  logic                    last_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    s1_valid_r, s1_last_r, s1_sign_r, s1_nz_r;
  logic [SUM_W-1:0]        s1_sum_r;
  logic                    s2_valid_r, s2_last_r;
  logic [WIDTH-1:0]        s2_term_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [WIDTH-1:0]        y_r;
  logic                    out_valid_r;

  logic [EXP_W-1:0]        exp_s;
  logic [EXP_W-1:0]        rsh_s;
  logic [WIDE_W-1:0]       mant_s;
  logic [WIDE_W-1:0]       wide_s;
  logic [WIDTH-1:0]        mag_s;
  logic [WIDTH-1:0]        term_s;
  logic signed [ACC_W-1:0] acc_next_s;
  logic [WIDTH-1:0]        y_next_s;

  assign en_s          = !(out_valid_r && !bus.out_ready);
  assign last_s        = (cnt_r == CNT_W'(TAPS - 1));
  assign bus.in_ready  = en_s;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;

  // Tap counter and S1 log-domain multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r      <= '0;
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_nz_r    <= 1'b0;
      s1_sum_r   <= '0;
    end else if (en_s) begin
      s1_valid_r <= bus.in_valid;
      s1_last_r  <= bus.in_valid && last_s;
      if (bus.in_valid) begin
        cnt_r     <= last_s ? '0 : cnt_r + 1'b1;
        s1_sign_r <= bus.log_a_sign ^ bus.log_b_sign;
        s1_nz_r   <= bus.log_a_valid & bus.log_b_valid;
        s1_sum_r  <= {bus.log_a[LOG_WIDTH-1], bus.log_a} + {bus.log_b[LOG_WIDTH-1], bus.log_b};
      end
    end
  end

  // Mitchell antilog of the log sum into a signed linear term.
  always_comb begin
    exp_s  = s1_sum_r[SUM_W-1:QP];
    rsh_s  = -exp_s;
    mant_s = {{(WIDE_W-QP-1){1'b0}}, 1'b1, s1_sum_r[QP-1:0]};
    if (exp_s[EXP_W-1] == 1'b0) begin
      wide_s = mant_s << exp_s;
    end else begin
      wide_s = mant_s >> rsh_s;
    end
`ifdef LOG_FIR_SAT_EN
    if (wide_s > MAG_MAX) begin
      mag_s = MAG_MAX[WIDTH-1:0];
    end else begin
      mag_s = wide_s[WIDTH-1:0];
    end
`else
    mag_s = wide_s;
`endif
    if (!s1_nz_r) begin
      term_s = '0;
    end else if (s1_sign_r) begin
      term_s = -mag_s;
    end else begin
      term_s = mag_s;
    end
  end

  // S2 register: antilog result and its sample tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_term_r  <= '0;
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_term_r  <= term_s;
    end
  end

  // Running sum and output reduction to WIDTH bits.
  always_comb begin
    acc_next_s = acc_r + {{(ACC_W-WIDTH){s2_term_r[WIDTH-1]}}, s2_term_r};
`ifdef LOG_FIR_SAT_EN
    if (acc_next_s > ACC_MAX) begin
      y_next_s = ACC_MAX[WIDTH-1:0];
    end else if (acc_next_s < ACC_MIN) begin
      y_next_s = ACC_MIN[WIDTH-1:0];
    end else begin
      y_next_s = acc_next_s[WIDTH-1:0];
    end
`else
    y_next_s = acc_next_s[WIDTH-1:0];
`endif
  end

  // S3 accumulate; a completing sample reloads y even while the old one is being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r       <= '0;
      y_r         <= '0;
      out_valid_r <= 1'b0;
    end else if (en_s) begin
      if (s2_valid_r && s2_last_r) begin
        y_r         <= y_next_s;
        acc_r       <= '0;
        out_valid_r <= 1'b1;
      end else begin
        if (s2_valid_r) begin
          acc_r <= acc_next_s;
        end
        if (bus.out_ready) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end
endmodule
